pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/cla_pkg.sv | 16 +
 rtl/pipelined_cla_adder_if.sv | 29 ++
 rtl/cla_slice.sv | 43 ++++
 rtl/pipelined_cla_adder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, op encoding and stage-count helper for the pipelined CLA adder
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_BLOCK = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } cla_op_e;

    function automatic int cla_stages(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for the pipelined CLA adder
interface pipelined_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    cla_op_e          op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, S, cout, overflow
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, S, cout, overflow
    );

endinterface

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational BLOCK-bit carry-lookahead slice
module cla_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_big_g,
    output logic             o_big_p,
    output logic             o_msb_cin
);

    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;
    logic             w_gg_acc;
    logic             w_pp_acc;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Each carry comes from the prefix group G/P of bits [i:0] and the block carry-in.
    always_comb begin
        w_gg_acc = 1'b0;
        w_pp_acc = 1'b1;
        w_c      = '0;
        w_c[0]   = i_cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_gg_acc = w_g[i] | (w_p[i] & w_gg_acc);
            w_pp_acc = w_pp_acc & w_p[i];
            w_c[i+1] = w_gg_acc | (w_pp_acc & i_cin);
        end
    end

    assign o_sum     = i_a ^ i_b ^ w_c[BLOCK-1:0];
    assign o_cout    = w_c[BLOCK];
    assign o_big_g   = w_gg_acc;
    assign o_big_p   = w_pp_acc;
    assign o_msb_cin = w_c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - WIDTH-bit add/subtract, one BLOCK-bit lookahead stage per pipeline register
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic                 clock,
    input  logic                 reset,
    pipelined_cla_adder_if.slave bus
);

    localparam int NB = cla_stages(WIDTH, BLOCK);

    if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    // The whole pipeline moves as one shift register gated by the output slot.
    assign w_advance    = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.S         = r_s;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

    assign w_b_eff = (bus.op == OP_SUB) ? ~bus.B : bus.B;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        localparam int REM  = WIDTH - k * BLOCK;
        localparam int DONE = (k + 1) * BLOCK;

        logic [REM-1:0]   w_a;
        logic [REM-1:0]   w_b;
        logic             w_cin;
        logic             w_vin;
        logic [BLOCK-1:0] w_sum;
        logic             w_big_g;
        logic             w_big_p;
        logic             w_msb_cin;
        logic             w_carry;
        logic             w_unused_ripple_cout;
        logic [DONE-1:0]  w_done;

        if (k == 0) begin : g_src
            assign w_a    = bus.A;
            assign w_b    = w_b_eff;
            assign w_cin  = (bus.op == OP_SUB);
            assign w_vin  = bus.in_valid;
            assign w_done = w_sum;
        end else begin : g_src
            assign w_a    = g_stage[k-1].g_mid.r_a;
            assign w_b    = g_stage[k-1].g_mid.r_b;
            assign w_cin  = g_stage[k-1].g_mid.r_c;
            assign w_vin  = g_stage[k-1].g_mid.r_v;
            assign w_done = {w_sum, g_stage[k-1].g_mid.r_lo};
        end

        cla_slice #(
            .BLOCK(BLOCK)
        ) u_slice (
            .i_a       (w_a[BLOCK-1:0]),
            .i_b       (w_b[BLOCK-1:0]),
            .i_cin     (w_cin),
            .o_sum     (w_sum),
            .o_cout    (w_unused_ripple_cout),
            .o_big_g   (w_big_g),
            .o_big_p   (w_big_p),
            .o_msb_cin (w_msb_cin)
        );

        assign w_carry = w_big_g | (w_big_p & w_cin);

        if (k == NB - 1) begin : g_last
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_out_valid <= 1'b0;
                    r_s         <= '0;
                    r_cout      <= 1'b0;
                    r_ovf       <= 1'b0;
                end else if (w_advance) begin
                    r_out_valid <= w_vin;
                    r_s         <= w_done;
                    r_cout      <= w_carry;
                    r_ovf       <= w_msb_cin ^ w_carry;
                end
            end
        end else begin : g_mid
            logic [REM-BLOCK-1:0] r_a;
            logic [REM-BLOCK-1:0] r_b;
            logic [DONE-1:0]      r_lo;
            logic                 r_c;
            logic                 r_v;
            logic                 w_unused_msb_cin;

            assign w_unused_msb_cin = w_msb_cin;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_v <= 1'b0;
                end else if (w_advance) begin
                    r_v <= w_vin;
                end
            end

            // Only the upper, not-yet-summed operand bits travel on.
            always_ff @(posedge clock) begin
                if (w_advance) begin
                    r_a  <= w_a[REM-1:BLOCK];
                    r_b  <= w_b[REM-1:BLOCK];
                    r_lo <= w_done;
                    r_c  <= w_carry;
                end
            end
        end
    end

endmodule
